// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 255;

    // Smallest counter width that can hold 0..max_val.
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use stalls, branch/jump flushes, data-memory wait freeze
// with timeout into a sticky error state, plus stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rt,
    input  logic             MemRead_EX,
    input  logic             Jump_EX,
    input  logic             Branch_taken_MEM,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             Pipe_Freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = width_for(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    logic mem_pend;
    logic load_use;
    logic freeze_now;
    logic hazard_eval;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic pipe_freeze;

    assign mem_pend = (MemRead_MEM | MemWrite_MEM) & ~dmem_ready;

    assign load_use = MemRead_EX && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Freeze decides first; events it masks are looked at again on the release cycle.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        freeze_now  = 1'b0;
        hazard_eval = 1'b0;

        case (state)
            RUN: begin
                if (mem_pend) begin
                    freeze_now = 1'b1;
                    state_nxt  = MEM_WAIT;
                    wait_nxt   = WAIT_ONE;
                end else begin
                    hazard_eval = 1'b1;
                    wait_nxt    = '0;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    freeze_now = 1'b1;
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_nxt = ERROR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_ONE;
                    end
                end else begin
                    hazard_eval = 1'b1;
                    state_nxt   = RUN;
                    wait_nxt    = '0;
                end
            end
            ERROR: begin
                freeze_now = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;

        if (rst_n) begin
            if (freeze_now) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (hazard_eval) begin
                if (Branch_taken_MEM) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (Jump_EX) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    assign PCWrite      = pc_write;
    assign IF_ID_Write  = if_id_write;
    assign IF_ID_Flush  = if_id_flush;
    assign ID_EX_Flush  = id_ex_flush;
    assign EX_MEM_Flush = ex_mem_flush;
    assign Pipe_Freeze  = pipe_freeze;
    assign mem_timeout  = (state == ERROR);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_write),
        .clr   (cnt_clr),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush | id_ex_flush | ex_mem_flush),
        .clr   (cnt_clr),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: behavioural model plus directed vectors.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic             id_uses_rt = 1'b0;
    logic [4:0]       ex_rt = '0;
    logic             MemRead_EX = 1'b0;
    logic             Jump_EX = 1'b0;
    logic             Branch_taken_MEM = 1'b0;
    logic             MemRead_MEM = 1'b0;
    logic             MemWrite_MEM = 1'b0;
    logic             dmem_ready = 1'b1;
    logic             cnt_clr = 1'b0;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             Pipe_Freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_rt            (ex_rt),
        .MemRead_EX       (MemRead_EX),
        .Jump_EX          (Jump_EX),
        .Branch_taken_MEM (Branch_taken_MEM),
        .MemRead_MEM      (MemRead_MEM),
        .MemWrite_MEM     (MemWrite_MEM),
        .dmem_ready       (dmem_ready),
        .cnt_clr          (cnt_clr),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Flush      (ID_EX_Flush),
        .EX_MEM_Flush     (EX_MEM_Flush),
        .Pipe_Freeze      (Pipe_Freeze),
        .mem_timeout      (mem_timeout),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    // Model: "dead" after too many consecutive frozen cycles, otherwise tracks whether a
    // memory access is still outstanding and how many cycles it has been frozen.
    bit m_dead = 1'b0;
    bit m_waiting = 1'b0;
    int m_frozen = 0;
    int m_stall = 0;
    int m_flush = 0;

    logic e_lu, e_block;
    logic e_pcw, e_ifw, e_f1, e_f2, e_f3, e_frz;

    always_comb begin
        e_lu    = MemRead_EX && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        e_block = m_dead || (m_waiting ? !dmem_ready : ((MemRead_MEM || MemWrite_MEM) && !dmem_ready));
        e_pcw = 1'b1;
        e_ifw = 1'b1;
        e_f1  = 1'b0;
        e_f2  = 1'b0;
        e_f3  = 1'b0;
        e_frz = 1'b0;
        if (rst_n) begin
            if (e_block) begin
                e_frz = 1'b1;
                e_pcw = 1'b0;
                e_ifw = 1'b0;
            end else if (Branch_taken_MEM) begin
                {e_f1, e_f2, e_f3} = 3'b111;
            end else if (Jump_EX) begin
                {e_f1, e_f2} = 2'b11;
            end else if (e_lu) begin
                e_pcw = 1'b0;
                e_ifw = 1'b0;
                e_f2  = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dead    <= 1'b0;
            m_waiting <= 1'b0;
            m_frozen  <= 0;
            m_stall   <= 0;
            m_flush   <= 0;
        end else begin
            m_stall <= cnt_clr ? 0 : (!e_pcw && m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
            m_flush <= cnt_clr ? 0 : ((e_f1 || e_f2 || e_f3) && m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
            if (!m_dead) begin
                if (e_frz) begin
                    m_frozen  <= m_frozen + 1;
                    m_waiting <= 1'b1;
                    if (m_frozen + 1 > MEM_TIMEOUT) m_dead <= 1'b1;
                end else begin
                    m_frozen  <= 0;
                    m_waiting <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        checkOutput("PCWrite", int'(PCWrite), int'(e_pcw));
        checkOutput("IF_ID_Write", int'(IF_ID_Write), int'(e_ifw));
        checkOutput("IF_ID_Flush", int'(IF_ID_Flush), int'(e_f1));
        checkOutput("ID_EX_Flush", int'(ID_EX_Flush), int'(e_f2));
        checkOutput("EX_MEM_Flush", int'(EX_MEM_Flush), int'(e_f3));
        checkOutput("Pipe_Freeze", int'(Pipe_Freeze), int'(e_frz));
        checkOutput("mem_timeout", int'(mem_timeout), int'(m_dead));
        checkOutput("stall_count", int'(stall_count), m_stall);
        checkOutput("flush_count", int'(flush_count), m_flush);
    end

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                 input logic [4:0] ert, input logic mrex, input logic jmp,
                                 input logic br, input logic mrm, input logic mwm,
                                 input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = ert;
        MemRead_EX = mrex; Jump_EX = jmp; Branch_taken_MEM = br;
        MemRead_MEM = mrm; MemWrite_MEM = mwm; dmem_ready = rdy; cnt_clr = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic clearCounters();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_timeout", int'(mem_timeout), 0);
        checkOutput("async_rst_stall", int'(stall_count), 0);
        checkOutput("async_rst_pcwrite", int'(PCWrite), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("reset_flush", int'(IF_ID_Flush), 0);
        checkOutput("reset_freeze", int'(Pipe_Freeze), 0);
        checkOutput("reset_stall", int'(stall_count), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        checkOutput("idle_pcwrite", int'(PCWrite), 1);

        // Load-use on rs
        applyStimulus(8, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("lu_pcwrite", int'(PCWrite), 0);
        checkOutput("lu_ifid_write", int'(IF_ID_Write), 0);
        checkOutput("lu_idex_flush", int'(ID_EX_Flush), 1);
        idle();
        checkOutput("lu_stall_count", int'(stall_count), 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("r0_no_stall", int'(PCWrite), 1);
        applyStimulus(3, 9, 1, 9, 1, 0, 0, 0, 0, 1, 0);
        applyStimulus(3, 9, 0, 9, 1, 0, 0, 0, 0, 1, 0);

        // Branch beats load-use, jump beats load-use
        clearCounters();
        applyStimulus(8, 0, 0, 8, 1, 0, 1, 0, 0, 1, 0);
        checkOutput("br_exmem_flush", int'(EX_MEM_Flush), 1);
        checkOutput("br_pcwrite", int'(PCWrite), 1);
        idle();
        checkOutput("br_flush_count", int'(flush_count), 1);
        checkOutput("br_stall_count", int'(stall_count), 0);
        applyStimulus(8, 0, 0, 8, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("jmp_exmem_flush", int'(EX_MEM_Flush), 0);

        // Store waits three cycles then completes
        clearCounters();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("wait_freeze", int'(Pipe_Freeze), 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("release_freeze", int'(Pipe_Freeze), 0);
        idle();
        checkOutput("wait_stall_count", int'(stall_count), 3);

        // Branch masked by freeze, honoured on release
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        idle();

        // Timeout into sticky error, cleared by reset
        clearCounters();
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        checkOutput("timeout_flag", int'(mem_timeout), 1);
        checkOutput("timeout_freeze", int'(Pipe_Freeze), 1);
        applyStimulus(8, 0, 0, 8, 1, 0, 1, 0, 0, 1, 0);
        checkOutput("timeout_sticky", int'(mem_timeout), 1);
        resetPulse();
        idle();

        // Reset in the middle of a wait
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        resetPulse();
        applyStimulus(5, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("post_reset_lu", int'(PCWrite), 0);

        // Counter saturation and clear-beats-increment
        clearCounters();
        repeat (5) applyStimulus(8, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0);
        idle();
        checkOutput("stall_saturate", int'(stall_count), 3);
        applyStimulus(8, 0, 0, 8, 1, 0, 0, 0, 0, 1, 1);
        idle();
        checkOutput("clr_beats_inc", int'(stall_count), 0);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        idle();
        checkOutput("flush_saturate", int'(flush_count), 3);

        idle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
